// File: rtl/hello_pkg.sv
// Shared constants for the HELLO banner: character codes, message table,
// position count, controller state encoding and pos arithmetic helpers.
package hello_pkg;

  localparam logic [2:0] CH_H     = 3'd0;
  localparam logic [2:0] CH_E     = 3'd1;
  localparam logic [2:0] CH_L     = 3'd2;
  localparam logic [2:0] CH_O     = 3'd3;
  localparam logic [2:0] CH_BLANK = 3'd4;

  localparam int NUM_POS = 6;

  localparam logic [2:0] MSG [NUM_POS] = '{CH_H, CH_E, CH_L, CH_L, CH_O, CH_BLANK};

  typedef enum logic [1:0] {
    PAUSE = 2'd0,
    RUN   = 2'd1,
    BLINK = 2'd2
  } state_e;

  // One rotation step mod 6; dir=0 increments, dir=1 decrements.
  function automatic logic [2:0] pos_step(input logic [2:0] p, input logic d);
    logic [2:0] r;
    if (d == 1'b0) begin
      r = (p >= 3'd5) ? 3'd0 : p + 3'd1;
    end else begin
      r = ((p == 3'd0) || (p > 3'd5)) ? 3'd5 : p - 3'd1;
    end
    return r;
  endfunction

  function automatic logic [2:0] pos_clamp(input logic [2:0] p);
    return (p > 3'd5) ? 3'd5 : p;
  endfunction

endpackage

// File: rtl/hello_rotator.sv
// Combinational map from rotation position to the six per-digit character
// codes: char_i = MSG[(4 - i + pos) mod 6].
module hello_rotator
  import hello_pkg::*;
(
  input  logic [2:0]                 pos_i,
  output logic [NUM_POS-1:0][2:0]    chars_o
);

  logic [4:0] idx;

  // Offset of 10 keeps the subtraction non-negative before the mod.
  always_comb begin
    chars_o = '0;
    idx     = 5'd0;
    for (int i = 0; i < NUM_POS; i++) begin
      idx        = (5'd10 - 5'(i) + {2'b00, pos_i}) % 5'd6;
      chars_o[i] = MSG[idx[2:0]];
    end
  end

endmodule

// File: rtl/hello_scroll_ctrl.sv
// HELLO banner scroll sequencer: prescaled auto-scroll, single-step, load.
// Define HELLO_SCROLL_BLINK_EN to blank the display for BLINK_TICKS steps after an automatic wrap.
module hello_scroll_ctrl
  import hello_pkg::*;
#(
  parameter int TICK_DIV    = 50_000_000,
  parameter int BLINK_TICKS = 2
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       run,
  input  logic       dir,
  input  logic       step,
  input  logic       load,
  input  logic [2:0] load_pos,
  output logic [2:0] pos,
  output logic [2:0] char0,
  output logic [2:0] char1,
  output logic [2:0] char2,
  output logic [2:0] char3,
  output logic [2:0] char4,
  output logic [2:0] char5,
  output logic       tick
);

  localparam int                  CNT_W    = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(TICK_DIV - 1);
  localparam int                  BLK_W    = $clog2(BLINK_TICKS) + 1;
  localparam logic [BLK_W-1:0]    BLK_LAST = BLK_W'(BLINK_TICKS - 1);
  localparam logic [NUM_POS-1:0][2:0] RESET_CHARS = {CH_BLANK, CH_H, CH_E, CH_L, CH_L, CH_O};

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BLK_W-1:0]        blk_q, blk_d;
  logic [2:0]              pos_q, pos_d;
  logic                    tick_q, tick_d;
  logic                    blank_d;
  logic                    adv_s;
  logic [NUM_POS-1:0][2:0] chars_q, rot_chars;

`ifdef HELLO_SCROLL_BLINK_EN
  logic wrap_s;
  // A load in the tick cycle overrides the step, so it cannot cause a wrap.
  assign wrap_s = tick_d && !load && (dir ? (pos_q == 3'd0) : (pos_q == 3'd5));
`endif

  hello_rotator u_rot (
    .pos_i   (pos_d),
    .chars_o (rot_chars)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    blk_d   = blk_q;
    tick_d  = (state_q != PAUSE) && (cnt_q == CNT_MAX);
    adv_s   = tick_d || ((state_q == PAUSE) && step);

    if (load) begin
      pos_d = pos_clamp(load_pos);
    end else if (adv_s) begin
      pos_d = pos_step(pos_q, dir);
    end else begin
      pos_d = pos_q;
    end

    case (state_q)
      PAUSE: begin
        cnt_d   = '0;
        state_d = run ? RUN : PAUSE;
      end
      RUN: begin
        cnt_d = tick_d ? '0 : cnt_q + CNT_W'(1);
        if (!run) begin
          state_d = PAUSE;
          cnt_d   = '0;
        end
`ifdef HELLO_SCROLL_BLINK_EN
        else if (wrap_s) begin
          state_d = BLINK;
          blk_d   = '0;
        end
`endif
        else begin
          state_d = RUN;
        end
      end
      BLINK: begin
        cnt_d = tick_d ? '0 : cnt_q + CNT_W'(1);
        if (tick_d && (blk_q == BLK_LAST)) begin
          state_d = run ? RUN : PAUSE;
          blk_d   = '0;
        end else if (tick_d) begin
          blk_d = blk_q + BLK_W'(1);
        end else begin
          blk_d = blk_q;
        end
      end
      default: begin
        state_d = PAUSE;
        cnt_d   = '0;
        blk_d   = '0;
      end
    endcase

    blank_d = (state_d == BLINK);
  end

  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q <= PAUSE;
      cnt_q   <= '0;
      blk_q   <= '0;
      pos_q   <= 3'd0;
      tick_q  <= 1'b0;
      chars_q <= RESET_CHARS;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      blk_q   <= blk_d;
      pos_q   <= pos_d;
      tick_q  <= tick_d;
      chars_q <= blank_d ? {NUM_POS{CH_BLANK}} : rot_chars;
    end
  end

  assign pos   = pos_q;
  assign tick  = tick_q;
  assign char0 = chars_q[0];
  assign char1 = chars_q[1];
  assign char2 = chars_q[2];
  assign char3 = chars_q[3];
  assign char4 = chars_q[4];
  assign char5 = chars_q[5];

endmodule
